// File: rtl/seg_pkg.sv
// Shared constants, slot record and nibble helper for the seven-segment scan path.
// The nibble helper is also used by the downstream BCD decoder.
package seg_pkg;

    localparam int unsigned SEG_NUM_DIGITS_DEF = 5;

    // One-hot select for digit 0, the slot shown straight out of reset
    localparam logic [SEG_NUM_DIGITS_DEF-1:0] SEG_SEL_RST = SEG_NUM_DIGITS_DEF'(1);

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Widest packed BCD value the nibble helper accepts (16 digits)
    localparam int unsigned SEG_BCD_MAX_W = 64;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       err;
    } seg_slot_t;

    function automatic logic [3:0] seg_nibble(input logic [SEG_BCD_MAX_W-1:0] value,
                                              input int unsigned             pos);
        logic [SEG_BCD_MAX_W-1:0] shifted;
        shifted = value >> (4 * pos);
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running slot prescaler: counts 0..PRESCALE-1 and flags the last count.
// PRESCALE must be 2 or more.
module seg_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned      CNT_W   = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// New values are latched through a load handshake and applied only at a frame boundary.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = SEG_NUM_DIGITS_DEF,
    parameter int unsigned PRESCALE   = 50000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    load_ack,
    output logic [3:0]              digit_val,
    output logic [NUM_DIGITS-1:0]   seg_sel,
    output logic                    blank,
    output logic                    bcd_err,
    output logic                    frame_tick
);

    localparam int unsigned      BCD_W    = 4 * NUM_DIGITS;
    localparam int unsigned      IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  slot_tick;
    logic                  boundary;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [BCD_W-1:0]      disp_q;
    logic [BCD_W-1:0]      disp_d;
    logic [BCD_W-1:0]      pend_q;
    logic [BCD_W-1:0]      pend_d;
    logic                  pend_vld_q;
    logic                  pend_vld_d;
    logic                  load_ack_d;
    logic                  load_ack_q;
    logic                  frame_tick_q;
    seg_slot_t             slot_d;
    seg_slot_t             slot_q;
    logic [NUM_DIGITS-1:0] seg_sel_d;
    logic [NUM_DIGITS-1:0] seg_sel_q;

    seg_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (slot_tick)
    );

    // Slot index; the wrap from the last digit marks the frame boundary
    always_comb begin
        idx_d    = idx_q;
        boundary = 1'b0;
        if (slot_tick) begin
            if (idx_q == LAST_IDX) begin
                idx_d    = '0;
                boundary = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // A load in the boundary cycle bypasses the pending register
    always_comb begin
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        load_ack_d = 1'b0;
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (load) begin
                disp_d     = bcd_in;
                load_ack_d = 1'b1;
            end else if (pend_vld_q) begin
                disp_d     = pend_q;
                load_ack_d = 1'b1;
            end
        end else if (load) begin
            pend_d     = bcd_in;
            pend_vld_d = 1'b1;
        end
    end

    // Slot view of the next index and next displayed value
    always_comb begin
        logic [3:0] nib;
        logic       upper_zero;
        nib        = seg_nibble(SEG_BCD_MAX_W'(disp_d), 32'(idx_d));
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((32'(i) >= 32'(idx_d)) &&
                (seg_nibble(SEG_BCD_MAX_W'(disp_d), 32'(i)) != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        slot_d.blank = BLANK_LZ && (idx_d != '0) && upper_zero;
        slot_d.digit = slot_d.blank ? 4'd0 : nib;
        slot_d.err   = !slot_d.blank && (nib > BCD_MAX);
        seg_sel_d    = slot_d.blank ? '0 : (NUM_DIGITS'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            slot_q       <= '0;
            seg_sel_q    <= NUM_DIGITS'(SEG_SEL_RST);
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= boundary;
            // Slot outputs move only on the edge that consumes slot_tick
            if (slot_tick) begin
                slot_q    <= slot_d;
                seg_sel_q <= seg_sel_d;
            end
        end
    end

    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;
    assign digit_val  = slot_q.digit;
    assign blank      = slot_q.blank;
    assign bcd_err    = slot_q.err;
    assign seg_sel    = seg_sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based display model feeds an expectation queue
// that a negedge monitor drains against a blanking and a non-blanking instance.
module tb_seg_scan_ctrl;

    localparam int ND    = 5;
    localparam int PS    = 4;
    localparam int FRAME = ND * PS;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [19:0] bcd_in = '0;

    logic       ack_a, blank_a, err_a, ft_a;
    logic [3:0] dv_a;
    logic [4:0] sel_a;
    logic       ack_b, blank_b, err_b, ft_b;
    logic [3:0] dv_b;
    logic [4:0] sel_b;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .PRESCALE  (PS),
        .BLANK_LZ  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .bcd_in    (bcd_in),
        .load_ack  (ack_a),
        .digit_val (dv_a),
        .seg_sel   (sel_a),
        .blank     (blank_a),
        .bcd_err   (err_a),
        .frame_tick(ft_a)
    );

    seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .PRESCALE  (PS),
        .BLANK_LZ  (1'b0)
    ) dut_nb (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .bcd_in    (bcd_in),
        .load_ack  (ack_b),
        .digit_val (dv_b),
        .seg_sel   (sel_b),
        .blank     (blank_b),
        .bcd_err   (err_b),
        .frame_tick(ft_b)
    );

    // Field order: digit_val, seg_sel, blank, bcd_err, load_ack, frame_tick
    typedef struct packed {
        logic [3:0] dv;
        logic [4:0] sel;
        logic       blank;
        logic       err;
        logic       ack;
        logic       ft;
    } obs_t;

    typedef struct packed {
        obs_t lz;
        obs_t nb;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    int          m_cyc  = 0;
    logic [19:0] m_disp = '0;
    logic [19:0] m_pend = '0;
    bit          m_pvld = 1'b0;

    function automatic obs_t view(logic [19:0] v, int s, bit blz, bit ack, bit ft);
        obs_t        o;
        logic [19:0] upper;
        upper   = v >> (4 * s);
        o.blank = blz && (s != 0) && (upper == 20'd0);
        o.dv    = o.blank ? 4'd0 : upper[3:0];
        o.sel   = o.blank ? 5'd0 : 5'(1 << s);
        o.err   = !o.blank && (upper[3:0] > 4'd9);
        o.ack   = ack;
        o.ft    = ft;
        return o;
    endfunction

    // Reference: cycles since reset give the slot, a frame is ND*PS cycles
    initial begin
        forever begin
            bit   ack;
            bit   ft;
            int   s;
            exp_t e;
            @(posedge clk);
            ack = 1'b0;
            ft  = 1'b0;
            if (!rst_n) begin
                m_cyc  = 0;
                m_disp = '0;
                m_pend = '0;
                m_pvld = 1'b0;
            end else begin
                if (m_cyc % FRAME == FRAME - 1) begin
                    ft = 1'b1;
                    if (load) begin
                        m_disp = bcd_in;
                        ack    = 1'b1;
                    end else if (m_pvld) begin
                        m_disp = m_pend;
                        ack    = 1'b1;
                    end
                    m_pvld = 1'b0;
                end else if (load) begin
                    m_pend = bcd_in;
                    m_pvld = 1'b1;
                end
                m_cyc++;
            end
            s    = (m_cyc / PS) % ND;
            e.lz = view(m_disp, s, 1'b1, ack, ft);
            e.nb = view(m_disp, s, 1'b0, ack, ft);
            exp_q.push_back(e);
        end
    end

    initial begin
        forever begin
            exp_t e;
            obs_t act;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {dv_a, sel_a, blank_a, err_a, ack_a, ft_a};
                checks++;
                if (act !== e.lz) begin
                    errors++;
                    $display("FAIL %s/blank_lz t=%0t actual=%b required=%b (dv,sel,blank,err,ack,ft)",
                             phase, $time, act, e.lz);
                end
                act = {dv_b, sel_b, blank_b, err_b, ack_b, ft_b};
                checks++;
                if (act !== e.nb) begin
                    errors++;
                    $display("FAIL %s/no_blank t=%0t actual=%b required=%b (dv,sel,blank,err,ack,ft)",
                             phase, $time, act, e.nb);
                end
            end
        end
    end

    task automatic pulse_load(input logic [19:0] v);
        load   = 1'b1;
        bcd_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Park on the negedge whose following posedge is frame position p
    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while ((m_cyc % FRAME != p) && (n < 3 * FRAME)) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        phase = "idle";
        repeat (45) @(negedge clk);

        phase = "basic";
        wait_pos(7);
        pulse_load(20'h12345);
        repeat (45) @(negedge clk);

        phase = "leading_zero";
        pulse_load(20'h00070);
        repeat (45) @(negedge clk);

        phase = "overwrite";
        wait_pos(3);
        pulse_load(20'h11111);
        repeat (4) @(negedge clk);
        pulse_load(20'h22222);
        repeat (45) @(negedge clk);

        phase = "bypass";
        wait_pos(FRAME - 1);
        pulse_load(20'h99999);
        repeat (30) @(negedge clk);

        phase = "bcd_err";
        pulse_load(20'h0000C);
        repeat (45) @(negedge clk);

        phase = "reset_pending";
        wait_pos(2);
        pulse_load(20'h54321);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);

        phase = "random";
        for (int k = 0; k < 1500; k++) begin
            logic [19:0] mask;
            case ($urandom_range(0, 4))
                0:       mask = 20'hFFFFF;
                1:       mask = 20'h000FF;
                2:       mask = 20'h00F0F;
                3:       mask = 20'h0000F;
                default: mask = 20'h00000;
            endcase
            load   = ($urandom_range(0, 7) == 0);
            bcd_in = 20'($urandom) & mask;
            rst_n  = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
